// File: rtl/node_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  node_mem_arbiter_pkg
//  Shared constants, read-tag type and pointer helper for node_mem_arbiter.
//  Rev 1.0
// ============================================================================
package node_mem_arbiter_pkg;

    localparam int MEM_LAT_DEF = 2;
    localparam int TAG_ID_W    = 3;   // wide enough for the largest NREQ (8)

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } rd_tag_t;

    function automatic logic [TAG_ID_W-1:0] wrap_inc(input logic [TAG_ID_W-1:0] idx,
                                                     input int                  n);
        return (idx == TAG_ID_W'(n - 1)) ? '0 : idx + TAG_ID_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/node_mem_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
//  node_mem_arbiter_rr_pick2
//  Combinational rotating picker: first two set requests from ptr upward.
//  Rev 1.0
// ============================================================================
module node_mem_arbiter_rr_pick2 #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic            win_a_vld_o,
    output logic [ID_W-1:0] win_a_idx_o,
    output logic            win_b_vld_o,
    output logic [ID_W-1:0] win_b_idx_o
);

    logic [2*NREQ-1:0] w_dbl;
    logic [NREQ-1:0]   w_rot;

    // Doubling the vector turns the modular scan into a plain slice.
    assign w_dbl = {req_i, req_i};
    assign w_rot = w_dbl[ptr_i +: NREQ];

    always_comb begin
        logic [ID_W:0] sum;
        win_a_vld_o = 1'b0;
        win_a_idx_o = '0;
        win_b_vld_o = 1'b0;
        win_b_idx_o = '0;
        sum         = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr_i} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(NREQ)) begin
                sum = sum - (ID_W+1)'(NREQ);
            end
            if (w_rot[k]) begin
                if (!win_a_vld_o) begin
                    win_a_vld_o = 1'b1;
                    win_a_idx_o = sum[ID_W-1:0];
                end else if (!win_b_vld_o) begin
                    win_b_vld_o = 1'b1;
                    win_b_idx_o = sum[ID_W-1:0];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/node_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  node_mem_arbiter
//  Shares node_memory ports a/b among NREQ requesters, routes reads back.
//  Rev 1.0
// ============================================================================
module node_mem_arbiter
    import node_mem_arbiter_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 36,
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_we,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_wdata,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [NREQ*DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0]      mem_rdaddr_a,
    output logic [ADDR_W-1:0]      mem_rdaddr_b,
    output logic [ADDR_W-1:0]      mem_wraddr_a,
    output logic [ADDR_W-1:0]      mem_wraddr_b,
    output logic                   mem_wren_a,
    output logic                   mem_wren_b,
    output logic [DATA_W-1:0]      mem_wrdata_a,
    output logic [DATA_W-1:0]      mem_wrdata_b,
    input  logic [DATA_W-1:0]      mem_q_a,
    input  logic [DATA_W-1:0]      mem_q_b,
    output logic [31:0]            stall_cnt
);

    localparam int ID_W = $clog2(NREQ);

    logic [ADDR_W-1:0] w_addr  [NREQ];
    logic [DATA_W-1:0] w_wdata [NREQ];
    logic              w_a_vld, w_b_vld, w_collide, w_grant_b, w_we_a, w_we_b;
    logic [ID_W-1:0]   w_a_idx, w_b_idx;
    logic [NREQ-1:0]   w_hit_a, w_hit_b, rsp_valid_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [31:0]       stall_q;
    logic              wren_a_q, wren_b_q;
    logic [ADDR_W-1:0] rdaddr_a_q, rdaddr_b_q, wraddr_a_q, wraddr_b_q;
    logic [DATA_W-1:0] wrdata_a_q, wrdata_b_q;
    rd_tag_t           tag_a_q [MEM_LAT+1];
    rd_tag_t           tag_b_q [MEM_LAT+1];
    logic [NREQ-1:0]   rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q [NREQ];

    generate
        for (genvar i = 0; i < NREQ; i++) begin : g_unpack
            assign w_addr[i]  = req_addr[i*ADDR_W +: ADDR_W];
            assign w_wdata[i] = req_wdata[i*DATA_W +: DATA_W];
            assign rsp_data[i*DATA_W +: DATA_W] = rsp_data_q[i];
        end
    endgenerate

    node_mem_arbiter_rr_pick2 #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_pick (
        .req_i       (req_valid),
        .ptr_i       (ptr_q),
        .win_a_vld_o (w_a_vld),
        .win_a_idx_o (w_a_idx),
        .win_b_vld_o (w_b_vld),
        .win_b_idx_o (w_b_idx)
    );

    assign w_we_a    = req_we[w_a_idx];
    assign w_we_b    = req_we[w_b_idx];
    assign w_collide = w_a_vld && w_b_vld && w_we_a && w_we_b &&
                       (w_addr[w_a_idx] == w_addr[w_b_idx]);
    assign w_grant_b = w_b_vld && !w_collide;

    always_comb begin
        ptr_d = ptr_q;
        if (w_grant_b) begin
            ptr_d = ID_W'(wrap_inc(TAG_ID_W'(w_b_idx), NREQ));
        end else if (w_a_vld) begin
            ptr_d = ID_W'(wrap_inc(TAG_ID_W'(w_a_idx), NREQ));
        end
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i]   = (w_a_vld   && (w_a_idx == ID_W'(i))) ||
                             (w_grant_b && (w_b_idx == ID_W'(i)));
            w_hit_a[i]     = tag_a_q[MEM_LAT].valid && (tag_a_q[MEM_LAT].id == TAG_ID_W'(i));
            w_hit_b[i]     = tag_b_q[MEM_LAT].valid && (tag_b_q[MEM_LAT].id == TAG_ID_W'(i));
            rsp_valid_d[i] = w_hit_a[i] || w_hit_b[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            stall_q     <= '0;
            wren_a_q    <= 1'b0;
            wren_b_q    <= 1'b0;
            rdaddr_a_q  <= '0;
            rdaddr_b_q  <= '0;
            wraddr_a_q  <= '0;
            wraddr_b_q  <= '0;
            wrdata_a_q  <= '0;
            wrdata_b_q  <= '0;
            rsp_valid_q <= '0;
            for (int s = 0; s <= MEM_LAT; s++) begin
                tag_a_q[s] <= '0;
                tag_b_q[s] <= '0;
            end
            for (int i = 0; i < NREQ; i++) begin
                rsp_data_q[i] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            if (w_collide && (stall_q != '1)) begin
                stall_q <= stall_q + 32'd1;
            end

            // Idle ports keep their addresses; only the write enable drops.
            wren_a_q <= w_a_vld && w_we_a;
            if (w_a_vld && w_we_a) begin
                wraddr_a_q <= w_addr[w_a_idx];
                wrdata_a_q <= w_wdata[w_a_idx];
            end
            if (w_a_vld && !w_we_a) begin
                rdaddr_a_q <= w_addr[w_a_idx];
            end
            wren_b_q <= w_grant_b && w_we_b;
            if (w_grant_b && w_we_b) begin
                wraddr_b_q <= w_addr[w_b_idx];
                wrdata_b_q <= w_wdata[w_b_idx];
            end
            if (w_grant_b && !w_we_b) begin
                rdaddr_b_q <= w_addr[w_b_idx];
            end

            tag_a_q[0] <= '{valid: w_a_vld && !w_we_a,   id: TAG_ID_W'(w_a_idx)};
            tag_b_q[0] <= '{valid: w_grant_b && !w_we_b, id: TAG_ID_W'(w_b_idx)};
            for (int s = 1; s <= MEM_LAT; s++) begin
                tag_a_q[s] <= tag_a_q[s-1];
                tag_b_q[s] <= tag_b_q[s-1];
            end

            rsp_valid_q <= rsp_valid_d;
            for (int i = 0; i < NREQ; i++) begin
                if (w_hit_a[i]) begin
                    rsp_data_q[i] <= mem_q_a;
                end else if (w_hit_b[i]) begin
                    rsp_data_q[i] <= mem_q_b;
                end
            end
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign mem_rdaddr_a = rdaddr_a_q;
    assign mem_rdaddr_b = rdaddr_b_q;
    assign mem_wraddr_a = wraddr_a_q;
    assign mem_wraddr_b = wraddr_b_q;
    assign mem_wren_a   = wren_a_q;
    assign mem_wren_b   = wren_b_q;
    assign mem_wrdata_a = wrdata_a_q;
    assign mem_wrdata_b = wrdata_b_q;
    assign stall_cnt    = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_node_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  tb_node_mem_arbiter
//  Directed and random traffic checked against a grant-order reference model.
//  Rev 1.0
// ============================================================================
module tb_node_mem_arbiter;

    localparam int NREQ    = 4;
    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 36;
    localparam int MEM_LAT = 2;
    localparam int RSP_DLY = MEM_LAT + 2;
    localparam int DEPTH   = 1 << ADDR_W;

    logic                   clk       = 1'b0;
    logic                   rst_n     = 1'b0;
    logic [NREQ-1:0]        req_valid = '0;
    logic [NREQ-1:0]        req_we    = '0;
    logic [NREQ*ADDR_W-1:0] req_addr  = '0;
    logic [NREQ*DATA_W-1:0] req_wdata = '0;
    logic [NREQ-1:0]        req_ready, rsp_valid;
    logic [NREQ*DATA_W-1:0] rsp_data;
    logic [ADDR_W-1:0]      mem_rdaddr_a, mem_rdaddr_b, mem_wraddr_a, mem_wraddr_b;
    logic                   mem_wren_a, mem_wren_b;
    logic [DATA_W-1:0]      mem_wrdata_a, mem_wrdata_b;
    logic [DATA_W-1:0]      mem_q_a = '0, mem_q_b = '0;
    logic [31:0]            stall_cnt;

    always #5 clk = ~clk;

    node_mem_arbiter #(
        .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .mem_rdaddr_a(mem_rdaddr_a), .mem_rdaddr_b(mem_rdaddr_b),
        .mem_wraddr_a(mem_wraddr_a), .mem_wraddr_b(mem_wraddr_b),
        .mem_wren_a(mem_wren_a), .mem_wren_b(mem_wren_b),
        .mem_wrdata_a(mem_wrdata_a), .mem_wrdata_b(mem_wrdata_b),
        .mem_q_a(mem_q_a), .mem_q_b(mem_q_b), .stall_cnt(stall_cnt)
    );

    // node_memory stand-in: read-before-write, MEM_LAT=2 read pipeline
    logic [DATA_W-1:0] ram [DEPTH];
    logic [DATA_W-1:0] s1_a = '0, s1_b = '0;
    always @(posedge clk) begin
        s1_a    <= ram[mem_rdaddr_a];
        s1_b    <= ram[mem_rdaddr_b];
        mem_q_a <= s1_a;
        mem_q_b <= s1_b;
        if (mem_wren_a) ram[mem_wraddr_a] <= mem_wrdata_a;
        if (mem_wren_b) ram[mem_wraddr_b] <= mem_wrdata_b;
    end

    // Reference: memory as seen in grant order, rr pointer, expected outputs
    logic [DATA_W-1:0] ref_mem [DEPTH];
    int                m_ptr;
    logic [31:0]       m_stall;
    logic              e_wren [2];
    logic [ADDR_W-1:0] e_rd   [2];
    logic [ADDR_W-1:0] e_wr   [2];
    logic [DATA_W-1:0] e_wd   [2];
    logic [NREQ-1:0]   e_rspv_sched [8];
    logic [DATA_W-1:0] e_rspd_sched [8][NREQ];
    logic [DATA_W-1:0] e_rsp_data   [NREQ];
    logic [NREQ-1:0]   last_rdy;
    int                cyc   = 0;
    int                total = 0;
    int                bad   = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", tag, cyc, act, exp);
        end
    endtask

    function automatic logic bit_of(input logic [NREQ-1:0] v, input int j);
        return ((v >> j) & NREQ'(1)) != '0;
    endfunction
    function automatic logic [ADDR_W-1:0] get_addr(input logic [NREQ*ADDR_W-1:0] a, input int j);
        return ADDR_W'(a >> (j*ADDR_W));
    endfunction
    function automatic logic [DATA_W-1:0] get_data(input logic [NREQ*DATA_W-1:0] d, input int j);
        return DATA_W'(d >> (j*DATA_W));
    endfunction

    task automatic model_clear();
        m_ptr   = 0;
        m_stall = '0;
        for (int p = 0; p < 2; p++) begin
            e_wren[p] = 1'b0; e_rd[p] = '0; e_wr[p] = '0; e_wd[p] = '0;
        end
        for (int s = 0; s < 8; s++) e_rspv_sched[s] = '0;
        for (int i = 0; i < NREQ; i++) e_rsp_data[i] = '0;
    endtask

    // One clock: check registered outputs, apply inputs, check grant, advance model
    task automatic step(input logic [NREQ-1:0] v, input logic [NREQ-1:0] we,
                        input logic [NREQ*ADDR_W-1:0] a, input logic [NREQ*DATA_W-1:0] d);
        logic [2:0]        slot, rs;
        int                win [2];
        logic [NREQ-1:0]   er;
        logic [ADDR_W-1:0] ad;
        @(negedge clk);
        cyc++;
        slot = 3'(cyc);
        chk("rsp_valid", 64'(rsp_valid), 64'(e_rspv_sched[slot]));
        for (int i = 0; i < NREQ; i++) begin
            if (bit_of(e_rspv_sched[slot], i)) e_rsp_data[i] = e_rspd_sched[slot][i];
            chk("rsp_data", 64'(get_data(rsp_data, i)), 64'(e_rsp_data[i]));
        end
        e_rspv_sched[slot] = '0;
        chk("wren_a",   64'(mem_wren_a),   64'(e_wren[0]));
        chk("wren_b",   64'(mem_wren_b),   64'(e_wren[1]));
        chk("rdaddr_a", 64'(mem_rdaddr_a), 64'(e_rd[0]));
        chk("rdaddr_b", 64'(mem_rdaddr_b), 64'(e_rd[1]));
        chk("wraddr_a", 64'(mem_wraddr_a), 64'(e_wr[0]));
        chk("wraddr_b", 64'(mem_wraddr_b), 64'(e_wr[1]));
        chk("wrdata_a", 64'(mem_wrdata_a), 64'(e_wd[0]));
        chk("wrdata_b", 64'(mem_wrdata_b), 64'(e_wd[1]));
        chk("stall_cnt", 64'(stall_cnt),   64'(m_stall));

        req_valid = v; req_we = we; req_addr = a; req_wdata = d;
        #1;
        win[0] = -1; win[1] = -1;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (m_ptr + k) % NREQ;
            if (bit_of(v, j)) begin
                if (win[0] < 0) win[0] = j;
                else if (win[1] < 0) win[1] = j;
            end
        end
        if (win[0] >= 0 && win[1] >= 0 && bit_of(we, win[0]) && bit_of(we, win[1]) &&
            get_addr(a, win[0]) == get_addr(a, win[1])) begin
            win[1] = -1;
            if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
        end
        er = '0;
        for (int p = 0; p < 2; p++) if (win[p] >= 0) er = er | (NREQ'(1) << win[p]);
        chk("req_ready", 64'(req_ready), 64'(er));
        last_rdy = req_ready;

        rs = 3'(cyc + RSP_DLY);
        for (int p = 0; p < 2; p++) begin
            e_wren[p] = 1'b0;
            if (win[p] >= 0 && !bit_of(we, win[p])) begin
                ad = get_addr(a, win[p]);
                e_rd[p] = ad;
                e_rspv_sched[rs] = e_rspv_sched[rs] | (NREQ'(1) << win[p]);
                e_rspd_sched[rs][win[p]] = ref_mem[ad];
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (win[p] >= 0 && bit_of(we, win[p])) begin
                ad = get_addr(a, win[p]);
                e_wren[p] = 1'b1;
                e_wr[p]   = ad;
                e_wd[p]   = get_data(d, win[p]);
                ref_mem[ad] = get_data(d, win[p]);
            end
        end
        if (win[1] >= 0) m_ptr = (win[1] + 1) % NREQ;
        else if (win[0] >= 0) m_ptr = (win[0] + 1) % NREQ;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step('0, '0, '0, '0);
    endtask

    task automatic rand_step(input logic [NREQ-1:0] vmask, input int arange);
        logic [NREQ*ADDR_W-1:0] a;
        logic [NREQ*DATA_W-1:0] d;
        for (int i = 0; i < NREQ; i++) begin
            a[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, arange));
            d[i*DATA_W +: DATA_W] = DATA_W'({$urandom, $urandom});
        end
        step(NREQ'($urandom) & vmask, NREQ'($urandom), a, d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req_valid = '0;
        #1;
        chk("rst_ready",     64'(req_ready),  64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid),  64'(0));
        chk("rst_rsp_data",  64'(|rsp_data), 64'(0));
        chk("rst_wren",      64'({mem_wren_a, mem_wren_b}), 64'(0));
        chk("rst_addrs",     64'(|{mem_rdaddr_a, mem_rdaddr_b, mem_wraddr_a, mem_wraddr_b}), 64'(0));
        chk("rst_wrdata",    64'(|{mem_wrdata_a, mem_wrdata_b}), 64'(0));
        chk("rst_stall",     64'(stall_cnt),  64'(0));
        repeat (3) @(negedge clk);
        chk("rst_hold_wren", 64'({mem_wren_a, mem_wren_b}), 64'(0));
        for (int k = 0; k < DEPTH; k++) ref_mem[k] = ram[k];
        model_clear();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [NREQ*ADDR_W-1:0] a;
        logic [NREQ*DATA_W-1:0] d;
        for (int k = 0; k < DEPTH; k++) ram[k] = '0;
        do_reset();

        // Write then read addr 5 from requester 0
        a = '0; d = '0;
        a[0 +: ADDR_W] = 10'd5;
        d[0 +: DATA_W] = 36'h123456789;
        step(4'b0001, 4'b0001, a, d);
        step(4'b0001, 4'b0000, a, '0);
        idle(RSP_DLY);
        chk("t2_rsp_valid", 64'(bit_of(rsp_valid, 0)), 64'(1));
        chk("t2_rsp_data",  64'(get_data(rsp_data, 0)), 64'h123456789);

        // Same-address write collision with ptr at 1
        a = '0; d = '0;
        a[1*ADDR_W +: ADDR_W] = 10'd9;  a[2*ADDR_W +: ADDR_W] = 10'd9;
        d[1*DATA_W +: DATA_W] = 36'hAAAAA0001; d[2*DATA_W +: DATA_W] = 36'hBBBBB0002;
        step(4'b0110, 4'b0110, a, d);
        chk("t4_first_ready", 64'(last_rdy), 64'(4'b0010));
        step(4'b0100, 4'b0100, a, d);
        chk("t4_second_ready", 64'(last_rdy), 64'(4'b0100));
        chk("t4_stall", 64'(stall_cnt), 64'(1));
        a = '0; a[0 +: ADDR_W] = 10'd9;
        step(4'b0001, 4'b0000, a, '0);
        idle(RSP_DLY);
        chk("t4_final_read", 64'(get_data(rsp_data, 0)), 64'hBBBBB0002);

        // Dual return: req0 addr 3, req3 addr 7 in the same cycle
        a = '0; d = '0;
        a[0 +: ADDR_W] = 10'd3; a[3*ADDR_W +: ADDR_W] = 10'd7;
        d[0 +: DATA_W] = 36'h333333333; d[3*DATA_W +: DATA_W] = 36'h777777777;
        step(4'b1001, 4'b1001, a, d);
        step(4'b1001, 4'b0000, a, '0);
        idle(RSP_DLY);
        chk("t5_dual_valid", 64'(rsp_valid), 64'(4'b1001));
        chk("t5_data0", 64'(get_data(rsp_data, 0)), 64'h333333333);
        chk("t5_data3", 64'(get_data(rsp_data, 3)), 64'h777777777);

        // Random traffic on a small address window to provoke collisions
        for (int k = 0; k < 1500; k++) rand_step('1, 7);

        // Reset in the middle of traffic, then a quiet interval
        do_reset();
        idle(10);

        // All four read continuously from ptr 0
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < NREQ; i++) a[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 15));
            step(4'b1111, 4'b0000, a, '0);
            chk("t3_rr", 64'(last_rdy), (k % 2 == 0) ? 64'(4'b0011) : 64'(4'b1100));
        end

        // Only requester 2 active
        for (int k = 0; k < 100; k++) begin
            rand_step(4'b0100, 15);
            chk("t6_ready", 64'(last_rdy & 4'b0100), 64'(bit_of(last_rdy, 2) ? 4'b0100 : 4'b0000));
            chk("t6_wren_b", 64'(mem_wren_b), 64'(0));
        end

        for (int k = 0; k < 1500; k++) rand_step('1, ($urandom_range(0, 3) == 0) ? DEPTH - 1 : 5);
        idle(RSP_DLY + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
